// File: rtl/fir_mac_filter.sv
// ---------------------------------------------------------------------------
// fir_mac_filter
//
// Time-multiplexed FIR filter. A single signed multiplier walks the taps, one
// tap per clock, so each sample takes TAPS MAC cycles. Coefficients are
// loaded at runtime while the filter is idle. The result is rounded
// half-up, shifted right by OUT_SHIFT, clamped to the DATA_W range and held
// on a ready/valid output port until the consumer takes it.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous active-low reset
//   in_valid    input sample valid
//   in_ready    block can accept a sample (high only in IDLE)
//   in_data     signed input sample, DATA_W bits
//   coef_we     coefficient write strobe (honoured only in IDLE)
//   coef_addr   coefficient index k
//   coef_wdata  signed coefficient value, COEF_W bits
//   coef_err    one-cycle pulse: a coefficient write was dropped
//   out_valid   filtered sample valid
//   out_ready   downstream accepts the sample
//   out_data    signed filtered sample, DATA_W bits
//   primed      TAPS output handshakes have completed since reset
//   sat         sticky: some output was clamped since reset
// ---------------------------------------------------------------------------
module fir_mac_filter #(
  parameter int TAPS      = 32,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 20,
  parameter int OUT_SHIFT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_wdata,
  output logic                      coef_err,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  out_data,
  output logic                      primed,
  output logic                      sat
);

  localparam int AW    = $clog2(TAPS);
  // Sample counter needs to hold the value TAPS itself.
  localparam int CW    = AW + 1;
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  // One guard bit so adding the rounding constant can never wrap.
  localparam int EW    = ACC_W + 1;

  localparam logic [AW-1:0] LAST_K = AW'(TAPS - 1);
  // TAPS truncated to AW bits; adding it wraps a negative index back into
  // [0, TAPS) for any TAPS, power of two or not.
  localparam logic [AW-1:0] TAPS_A = AW'(TAPS);
  localparam logic [CW-1:0] TAPS_C = CW'(TAPS);

  localparam logic signed [EW-1:0] RND     = EW'(1'b1) << (OUT_SHIFT - 1);
  localparam logic signed [EW-1:0] OUT_MAX = (EW'(1'b1) << (DATA_W - 1)) - EW'(1'b1);
  localparam logic signed [EW-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                     state_r;
  logic [AW-1:0]              k_r;
  logic [AW-1:0]              wr_ptr_r;
  logic [CW-1:0]              cnt_r;
  logic signed [ACC_W-1:0]    acc_r;
  logic signed [COEF_W-1:0]   coef_r [TAPS];
  logic signed [DATA_W-1:0]   dline_r [TAPS];

  logic                       in_ready_r;
  logic                       out_valid_r;
  logic signed [DATA_W-1:0]   out_data_r;
  logic                       coef_err_r;
  logic                       primed_r;
  logic                       sat_r;

  logic [AW-1:0]              rd_idx_s;
  logic signed [DATA_W-1:0]   x_s;
  logic signed [COEF_W-1:0]   c_s;
  logic signed [PW-1:0]       prod_s;
  logic signed [ACC_W-1:0]    acc_next_s;
  logic signed [EW-1:0]       shifted_s;
  logic signed [DATA_W-1:0]   out_next_s;
  logic                       clamp_s;

  // Delay-line read index for tap k: newest sample minus k, modulo TAPS.
  always_comb begin
    rd_idx_s = '0;
    if (k_r <= wr_ptr_r) begin
      rd_idx_s = wr_ptr_r - k_r;
    end else begin
      rd_idx_s = wr_ptr_r - k_r + TAPS_A;
    end
  end

  // Shared multiplier, accumulate, round-half-up, shift and clamp.
  always_comb begin
    x_s        = '0;
    c_s        = coef_r[k_r];
    // cnt_r counts samples completed before this one, so taps up to and
    // including cnt_r reach real samples; older slots hold pre-reset junk.
    if ({1'b0, k_r} <= cnt_r) begin
      x_s = dline_r[rd_idx_s];
    end else begin
      x_s = '0;
    end
    prod_s     = PW'(x_s) * PW'(c_s);
    acc_next_s = acc_r + ACC_W'(prod_s);
    shifted_s  = (EW'(acc_next_s) + RND) >>> OUT_SHIFT;
    out_next_s = shifted_s[DATA_W-1:0];
    clamp_s    = 1'b0;
    if (shifted_s > OUT_MAX) begin
      out_next_s = OUT_MAX[DATA_W-1:0];
      clamp_s    = 1'b1;
    end else if (shifted_s < OUT_MIN) begin
      out_next_s = OUT_MIN[DATA_W-1:0];
      clamp_s    = 1'b1;
    end else begin
      out_next_s = shifted_s[DATA_W-1:0];
      clamp_s    = 1'b0;
    end
  end

  // Delay-line storage; deliberately left unreset, stale history is masked
  // by the sample count instead.
  always_ff @(posedge clk) begin
    if ((state_r == IDLE) && in_valid) begin
      dline_r[wr_ptr_r] <= in_data;
    end
  end

  // Control FSM, coefficient bank, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      k_r         <= '0;
      wr_ptr_r    <= '0;
      cnt_r       <= '0;
      acc_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      coef_err_r  <= 1'b0;
      primed_r    <= 1'b0;
      sat_r       <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        coef_r[i] <= '0;
      end
    end else begin
      // Writes are only safe while no MAC is reading the bank. A write in
      // the accepting IDLE cycle lands before MAC tap 0 reads it.
      coef_err_r <= 1'b0;
      if (coef_we) begin
        if (state_r == IDLE) begin
          coef_r[coef_addr] <= coef_wdata;
        end else begin
          coef_err_r <= 1'b1;
        end
      end

      case (state_r)
        IDLE: begin
          if (in_valid) begin
            acc_r      <= '0;
            k_r        <= '0;
            in_ready_r <= 1'b0;
            state_r    <= MAC;
          end
        end

        MAC: begin
          acc_r <= acc_next_s;
          if (k_r == LAST_K) begin
            // Final tap: the output is formed from the last partial sum
            // directly so out_valid rises on this edge.
            out_data_r  <= out_next_s;
            out_valid_r <= 1'b1;
            if (clamp_s) begin
              sat_r <= 1'b1;
            end
            state_r <= OUT;
          end else begin
            k_r <= k_r + 1'b1;
          end
        end

        OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
            if (wr_ptr_r == LAST_K) begin
              wr_ptr_r <= '0;
            end else begin
              wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (cnt_r != TAPS_C) begin
              cnt_r <= cnt_r + 1'b1;
            end
            if (cnt_r == (TAPS_C - 1'b1)) begin
              primed_r <= 1'b1;
            end
          end
        end

        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign coef_err  = coef_err_r;
  assign primed    = primed_r;
  assign sat       = sat_r;

endmodule

// File: tb/tb_fir_mac_filter.sv
// ---------------------------------------------------------------------------
// tb_fir_mac_filter
//
// Directed bench for fir_mac_filter. One instance at the default parameters
// (TAPS=32, DATA_W=16, COEF_W=20, OUT_SHIFT=16) and one small instance
// (TAPS=4, DATA_W=8, COEF_W=8, OUT_SHIFT=4). Expected values are worked out
// by hand in the comments next to each vector. Latency is counted in edges
// with the accepting edge as edge 1, so TAPS+1 edges means out_valid is
// seen right after the edge that finishes tap TAPS-1.
// ---------------------------------------------------------------------------
module tb_fir_mac_filter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   out_cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // Default-parameter instance
  logic                in_valid, in_ready, coef_we, coef_err;
  logic                out_valid, out_ready, primed, sat;
  logic signed [15:0]  in_data, out_data;
  logic [4:0]          coef_addr;
  logic signed [19:0]  coef_wdata;

  // Small instance
  logic                in_valid4, in_ready4, coef_we4, coef_err4;
  logic                out_valid4, out_ready4, primed4, sat4;
  logic signed [7:0]   in_data4, out_data4, coef_wdata4;
  logic [1:0]          coef_addr4;

  fir_mac_filter u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_err(coef_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .primed(primed), .sat(sat)
  );

  fir_mac_filter #(.TAPS(4), .DATA_W(8), .COEF_W(8), .OUT_SHIFT(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .coef_we(coef_we4), .coef_addr(coef_addr4), .coef_wdata(coef_wdata4),
    .coef_err(coef_err4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .primed(primed4), .sat(sat4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; coef_we4 = 1'b0; out_ready4 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic write_coef(input logic [4:0] a, input logic signed [19:0] v);
    coef_we = 1'b1; coef_addr = a; coef_wdata = v;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic write_coef4(input logic [1:0] a, input logic signed [7:0] v);
    coef_we4 = 1'b1; coef_addr4 = a; coef_wdata4 = v;
    @(posedge clk); #1;
    coef_we4 = 1'b0;
  endtask

  // Wait until out_valid after an accept, bounded; lat counts accept edge as 1.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    out_cyc = cyc;
  endtask

  // Present one sample, collect its output, complete the handshake.
  task automatic send(input logic signed [15:0] d, output logic signed [15:0] y,
                      output int lat);
    int n;
    n = 0;
    in_data = d;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    y = out_data;
    @(posedge clk); #1;
  endtask

  task automatic send4(input logic signed [7:0] d, output logic signed [7:0] y,
                       output int lat);
    int n;
    n = 0;
    in_data4 = d;
    in_valid4 = 1'b1;
    while (!in_ready4 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 1;
    while (!out_valid4 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    y = out_data4;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_data !== 16'sd0) begin n_err++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    n_vec++; if (coef_err !== 1'b0) begin n_err++; $display("FAIL reset_coef_err: got %b expected 0", coef_err); end
    n_vec++; if (primed !== 1'b0) begin n_err++; $display("FAIL reset_primed: got %b expected 0", primed); end
    n_vec++; if (sat !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %b expected 0", sat); end
  endtask

  // coef[k] = k*4096 (k/16); impulse of 16 -> output n = n.
  task automatic test_impulse();
    logic signed [15:0] y;
    int lat, c0;
    c0 = 0;
    do_reset();
    for (int k = 0; k < 32; k++) write_coef(5'(k), 20'(k * 4096));
    for (int n = 0; n < 32; n++) begin
      send((n == 0) ? 16'sd16 : 16'sd0, y, lat);
      n_vec++;
      if (y !== 16'(n)) begin n_err++; $display("FAIL impulse[%0d]: got %0d expected %0d", n, y, n); end
      if (n == 0) begin
        c0 = out_cyc;
        n_vec++;
        if (lat !== 33) begin n_err++; $display("FAIL impulse_latency: got %0d edges expected 33", lat); end
      end
      if (n == 1) begin
        n_vec++;
        if (out_cyc - c0 !== 34) begin n_err++; $display("FAIL throughput: got %0d cycles expected 34", out_cyc - c0); end
      end
      if (n == 30) begin
        n_vec++;
        if (primed !== 1'b0) begin n_err++; $display("FAIL primed_early: got %b expected 0", primed); end
      end
      if (n == 31) begin
        n_vec++;
        if (primed !== 1'b1) begin n_err++; $display("FAIL primed_32nd: got %b expected 1", primed); end
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    do_reset();
    write_coef(5'd0, 20'sd65536);
    out_ready = 1'b0;
    in_data = 16'sd1234; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    n_vec++; if (lat !== 33) begin n_err++; $display("FAIL bp_latency: got %0d edges expected 33", lat); end
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (out_data !== 16'sd1234 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got data %0d valid %b in_ready %b expected 1234 1 0", i, out_data, out_valid, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_rounding();
    logic signed [15:0] y;
    int lat;
    do_reset();
    write_coef(5'd0, 20'sd98304);            // 1.5
    send(16'sd3, y, lat);                    // 4.5 -> 5
    n_vec++; if (y !== 16'sd5) begin n_err++; $display("FAIL round_pos: got %0d expected 5", y); end
    send(-16'sd3, y, lat);                   // -4.5 -> -4
    n_vec++; if (y !== -16'sd4) begin n_err++; $display("FAIL round_neg: got %0d expected -4", y); end
    send(16'sd1, y, lat);                    // 1.5 -> 2
    n_vec++; if (y !== 16'sd2) begin n_err++; $display("FAIL round_one: got %0d expected 2", y); end
    n_vec++; if (sat !== 1'b0) begin n_err++; $display("FAIL round_sat: got %b expected 0", sat); end
  endtask

  task automatic test_saturation();
    logic signed [15:0] y;
    int lat;
    do_reset();
    for (int k = 0; k < 32; k++) write_coef(5'(k), 20'sd65536);
    for (int n = 0; n < 32; n++) begin
      send(16'sh7FFF, y, lat);
      if (n == 0) begin
        n_vec++;
        if (y !== 16'sh7FFF || sat !== 1'b0) begin n_err++; $display("FAIL sat_first: got %0d sat %b expected 32767 0", y, sat); end
      end
      if (n == 31) begin
        n_vec++;
        if (y !== 16'sh7FFF || sat !== 1'b1) begin n_err++; $display("FAIL sat_last: got %0d sat %b expected 32767 1", y, sat); end
      end
    end
    // Negative clamp: -32768 exact, then -65536 clamps.
    do_reset();
    write_coef(5'd0, 20'sd65536);
    write_coef(5'd1, 20'sd65536);
    send(16'sh8000, y, lat);
    n_vec++; if (y !== 16'sh8000 || sat !== 1'b0) begin n_err++; $display("FAIL sat_neg_exact: got %0d sat %b expected -32768 0", y, sat); end
    send(16'sh8000, y, lat);
    n_vec++; if (y !== 16'sh8000 || sat !== 1'b1) begin n_err++; $display("FAIL sat_neg_clamp: got %0d sat %b expected -32768 1", y, sat); end
  endtask

  task automatic test_coef_drop();
    logic signed [15:0] y;
    int lat;
    do_reset();
    write_coef(5'd0, 20'sd65536);
    in_data = 16'sd100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    coef_we = 1'b1; coef_addr = 5'd0; coef_wdata = 20'sd131072;
    @(posedge clk); #1;
    coef_we = 1'b0;
    n_vec++; if (coef_err !== 1'b1) begin n_err++; $display("FAIL coef_err_pulse: got %b expected 1", coef_err); end
    @(posedge clk); #1;
    n_vec++; if (coef_err !== 1'b0) begin n_err++; $display("FAIL coef_err_clear: got %b expected 0", coef_err); end
    wait_out(lat);
    n_vec++; if (out_data !== 16'sd100) begin n_err++; $display("FAIL coef_drop_out: got %0d expected 100", out_data); end
    @(posedge clk); #1;
    send(16'sd50, y, lat);                   // coef[0] still 1.0
    n_vec++; if (y !== 16'sd50) begin n_err++; $display("FAIL coef_drop_next: got %0d expected 50", y); end
    // Write in the accepting IDLE cycle applies to that sample: 7 * 2.0 = 14.
    coef_we = 1'b1; coef_addr = 5'd0; coef_wdata = 20'sd131072;
    in_data = 16'sd7; in_valid = 1'b1;
    @(posedge clk); #1;
    coef_we = 1'b0; in_valid = 1'b0;
    n_vec++; if (coef_err !== 1'b0) begin n_err++; $display("FAIL coef_idle_err: got %b expected 0", coef_err); end
    wait_out(lat);
    n_vec++; if (out_data !== 16'sd14) begin n_err++; $display("FAIL coef_same_cycle: got %0d expected 14", out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mac();
    logic signed [15:0] y;
    int lat;
    bit seen;
    seen = 1'b0;
    do_reset();
    write_coef(5'd0, 20'sd65536);
    in_data = 16'sd500; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL midmac_async: got in_ready %b out_valid %b expected 1 0", in_ready, out_valid); end
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL midmac_no_output: got %b expected 0", seen); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midmac_in_ready: got %b expected 1", in_ready); end
    send(16'sd1000, y, lat);                 // all coefficients cleared
    n_vec++; if (y !== 16'sd0) begin n_err++; $display("FAIL midmac_coef_zero: got %0d expected 0", y); end
  endtask

  // coef = 1.0, 2.0, -1.0, 0.5 (Q4). Hand-computed window sums:
  //  160->10, 1920->120, 2240->140 clamp 127, -1088->-68,
  //  3616->226 clamp 127, -6480->-405 clamp -128.
  task automatic test_small_params();
    logic signed [7:0] din  [6];
    logic signed [7:0] dexp [6];
    logic signed [7:0] y;
    int lat;
    din  = '{8'sd10, 8'sd100, 8'shCE, 8'sd127, 8'sh80, 8'sd3};
    dexp = '{8'sd10, 8'sd120, 8'sd127, 8'shBC, 8'sd127, 8'sh80};
    do_reset();
    write_coef4(2'd0, 8'sh10);
    write_coef4(2'd1, 8'sh20);
    write_coef4(2'd2, 8'shF0);
    write_coef4(2'd3, 8'sh08);
    for (int i = 0; i < 6; i++) begin
      send4(din[i], y, lat);
      n_vec++;
      if (y !== dexp[i]) begin n_err++; $display("FAIL small[%0d]: got %0d expected %0d", i, y, dexp[i]); end
      n_vec++;
      if (lat !== 5) begin n_err++; $display("FAIL small_latency[%0d]: got %0d edges expected 5", i, lat); end
      if (i == 1) begin
        n_vec++;
        if (sat4 !== 1'b0 || primed4 !== 1'b0) begin n_err++; $display("FAIL small_flags1: got sat %b primed %b expected 0 0", sat4, primed4); end
      end
      if (i == 2) begin
        n_vec++;
        if (sat4 !== 1'b1 || primed4 !== 1'b0) begin n_err++; $display("FAIL small_flags2: got sat %b primed %b expected 1 0", sat4, primed4); end
      end
      if (i == 3) begin
        n_vec++;
        if (primed4 !== 1'b1) begin n_err++; $display("FAIL small_primed: got %b expected 1", primed4); end
      end
    end
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; out_ready = 1'b1;
    in_valid4 = 1'b0; in_data4 = '0; coef_we4 = 1'b0; coef_addr4 = '0; coef_wdata4 = '0; out_ready4 = 1'b1;
    test_reset();
    test_impulse();
    test_backpressure();
    test_rounding();
    test_saturation();
    test_coef_drop();
    test_reset_mid_mac();
    test_small_params();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
